// File: rtl/mem_io_responder.sv
// Memory-port responder: IO register file plus data-memory pass-through.
// Owns switch/button synchronisers, button debounce and 7-seg scanning.
module mem_io_responder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  input  logic [15:0] switch,
  input  logic        btnl,
  input  logic        btnr,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SC_LAST = SW'(SCAN_DIV - 1);

  logic        io_sel;
  logic        io_wr;
  logic [4:0]  off;
  logic        sel_st;
  logic        sel_sw;
  logic        sel_dp;
  logic        sel_led;
  logic [31:0] io_rdata;
  logic        unused_adr;

  assign io_sel  = (adr[31:8] == 24'd0) & adr[7];
  assign off     = adr[6:2];
  assign io_wr   = memwrite & io_sel;
  assign mem_we  = memwrite & ~io_sel;
  assign sel_st  = (off == 5'd0);
  assign sel_sw  = (off == 5'd1);
  assign sel_dp  = (off == 5'd2);
  assign sel_led = (off == 5'd3);
  assign unused_adr = ^adr[1:0];

  logic [15:0] sw_s1;
  logic [15:0] sw_s2;
  logic [1:0]  bt_s1;
  logic [1:0]  bt_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
      bt_s1 <= '0;
      bt_s2 <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
      bt_s1 <= {btnr, btnl};
      bt_s2 <= bt_s1;
    end
  end

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]    lvl;
  logic [1:0]    lvl_n;
  logic [1:0]    done;
  logic [1:0]    ev;
  logic [1:0]    ev_n;
  logic [1:0]    clr;
  logic [DW-1:0] cnt   [2];
  logic [DW-1:0] cnt_n [2];

  always_comb begin
    done  = '0;
    lvl_n = lvl;
    for (int b = 0; b < 2; b++) begin
      cnt_n[b] = '0;
      done[b]  = (bt_s2[b] != lvl[b]) && (cnt[b] == DB_LAST);
      lvl_n[b] = lvl[b] ^ done[b];
      if ((bt_s2[b] != lvl[b]) && !done[b])
        cnt_n[b] = cnt[b] + DW'(1);
    end
  end

  // A rising debounced edge in the same cycle as a clear keeps the flag set.
  assign clr  = (io_wr & sel_st) ? writedata[1:0] : 2'b00;
  assign ev_n = (ev & ~clr) | (done & ~lvl);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl <= '0;
      ev  <= '0;
      for (int b = 0; b < 2; b++)
        cnt[b] <= '0;
    end else begin
      lvl <= lvl_n;
      ev  <= ev_n;
      for (int b = 0; b < 2; b++)
        cnt[b] <= cnt_n[b];
    end
  end

  logic [31:0] display;
  logic [15:0] ledr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      display <= '0;
      ledr    <= '0;
    end else begin
      if (io_wr & sel_dp)
        display <= writedata;
      if (io_wr & sel_led)
        ledr <= writedata[15:0];
    end
  end

  assign led = ledr;

  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      sel_st:  io_rdata = {28'd0, lvl, ev};
      sel_sw:  io_rdata = {16'd0, sw_s2};
      sel_dp:  io_rdata = display;
      sel_led: io_rdata = {16'd0, ledr};
      default: io_rdata = '0;
    endcase
  end

  assign readdata = io_sel ? io_rdata : mem_rdata;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'ha: g = 7'b0001000;
      4'hb: g = 7'b0000011;
      4'hc: g = 7'b1000110;
      4'hd: g = 7'b0100001;
      4'he: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  logic [SW-1:0] div;
  logic [2:0]    idx;
  logic [3:0]    nib;
  logic [7:0]    an_r;
  logic [6:0]    seg_r;

  assign nib = display[{idx, 2'b00} +: 4];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      idx   <= '0;
      an_r  <= 8'hfe;
      seg_r <= 7'b1000000;
    end else begin
      if (div == SC_LAST) begin
        div <= '0;
        idx <= idx + 3'd1;
      end else begin
        div <= div + SW'(1);
      end
      an_r  <= ~(8'd1 << idx);
      seg_r <= hex7(nib);
    end
  end

  assign an  = an_r;
  assign seg = seg_r;

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder side of the multicycle datapath's memory port.
- Decodes `adr` / `memwrite` from the processor and serves two regions: a memory-mapped IO register file (switches, buttons, LEDs, 8-digit 7-segment display) and a pass-through to data memory.
- Owns all board-side sequencing: input synchronisation, button debounce with sticky event flags, and 7-segment multiplex scanning.
- Sits between the datapath/controller top and the board pins.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable synced samples before a button level is accepted.
- SCAN_DIV, 100000, clock cycles each 7-segment digit stays lit.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- memwrite  input  1  write strobe from controller.
- adr  input  32  byte address from datapath.
- writedata  input  32  store data from datapath.
- readdata  output  32  load data to datapath.
- mem_rdata  input  32  read data from data memory.
- mem_we  output  1  write enable to data memory.
- switch  input  16  board slide switches, asynchronous.
- btnl  input  1  left push-button, asynchronous, active-high.
- btnr  input  1  right push-button, asynchronous, active-high.
- led  output  16  LED outputs.
- an  output  8  digit enables, active-low.
- seg  output  7  segments a..g, active-low (`seg[0]`=a).

Behaviour:
- Decode:
  - `io_sel = (adr[31:8]==0) & adr[7]`.
  - Word offset is `adr[6:2]`; `adr[1:0]` is ignored.
  - `mem_we = memwrite & ~io_sel`.
  - `readdata = io_sel ? io_rdata : mem_rdata`.
- Read timing: combinational from `adr`, zero-latency. Reads have no side effects, because the datapath may hold `adr` for several cycles.
- Write timing: IO registers update on the rising `clk` edge where `memwrite & io_sel`.
- IO map (byte address):
  - 0x80 STATUS:
    - bit0 = L event, bit1 = R event, sticky.
    - bit2 = L debounced level, bit3 = R debounced level.
    - Other bits read 0.
    - Writes are write-1-to-clear on bits [1:0]; other bits are ignored.
  - 0x84 SWITCH: read-only; `{16'b0, switch_sync}`. Writes are ignored.
  - 0x88 DISPLAY: read/write, 32 bits, eight hex nibbles. Nibble k is shown on digit k (`an[k]`).
  - 0x8C LED: read/write; bits [15:0] drive `led`. Read returns `{16'b0, led}`.
  - 0x90–0xFC: read 0; writes are ignored.
- Synchronisers:
  - `switch`, `btnl` and `btnr` each pass through 2 flip-flops before use.
  - `switch_sync` latency is 2 cycles.
- Debounce (per button):
  - Counter resets to 0 whenever the synced sample equals the current debounced level, or differs from the previous synced sample.
  - When the sample has differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- Event flags:
  - An event bit is set on the cycle the debounced level goes 0→1.
  - It is cleared by a W1C write.
  - If set and clear happen in the same cycle, set wins.
  - A 1→0 transition sets nothing.
- Display scan:
  - The divider counts 0..SCAN_DIV-1.
  - At terminal count the digit index advances 0→1→…→7→0 (wrap).
  - Exactly one `an` bit is low at all times: `an = ~(8'b1 << idx)`.
  - `seg` is the hex decode (0–F, standard 7-seg glyphs, active-low) of `DISPLAY[4*idx+3 : 4*idx]`.
  - Outputs are registered, so `seg`/`an` change together one cycle after the index changes.
  - A DISPLAY write is visible on the current digit within 2 cycles, with no scan restart.
- Reset (reset=0, asynchronous, any time including mid-debounce or mid-scan):
  - All synchronisers, counters and debounced levels = 0.
  - Event flags = 0.
  - DISPLAY = 0, LED = 0, idx = 0.
  - `an` = 8'hFE, `seg` = 7'b1000000 (glyph "0"), `led` = 0.
- Non-IO accesses never modify IO state.
- Memory writes are blocked when `io_sel`.

Test Plan:
- Reset, then hold reset=1 with no stimulus → `led`=0, `an`=8'hFE, `seg`=7'h40, read 0x80/0x88/0x8C=0, `mem_we` low. Assert reset mid-scan → same values immediately, without waiting for a clk edge.
- Write 0x8C←0x0001_A5A5, then read 0x8C → `led`=16'hA5A5, readdata=0x0000_A5A5. Write 0x84 and 0x9C → no state change, read 0x9C=0. Write 0x40 → `mem_we`=1 for that cycle only.
- DEBOUNCE_CYCLES=4: press `btnl` 3 cycles → STATUS stays 0. Press 10 cycles → STATUS=0x5 after 2+4 cycles. Release → STATUS=0x1 (event sticky). Write 0x80←0x1 → STATUS=0x0.
- W1C collision: schedule the R debounced rise on the same cycle as write 0x80←0x2 → STATUS bit1=1 afterward.
- SCAN_DIV=2, DISPLAY←0x0123_4567 → `an` sequence FE,FD,…,7F,FE, each held 2 cycles. `seg` at idx0=glyph 7 (7'b1111000), idx7=glyph 0 (7'b1000000).
- Set `switch`=16'hBEEF → read 0x84 returns 0x0000_BEEF from the 3rd cycle on. Set `mem_rdata`=0xDEADBEEF, adr=0x100 → readdata=0xDEADBEEF.
